// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the parametrised synchronous FIFO:
//   - default parameter values
//   - cnt_w(depth): width of a fill count covering 0..depth inclusive
//   - ptr_w(depth): width of a storage pointer covering 0..depth-1
package fifo_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DEPTH     = 32;
    localparam int DEF_AFULL_TH  = DEF_DEPTH - 2;
    localparam int DEF_AEMPTY_TH = 2;

    // The count must be able to represent DEPTH itself, hence depth+1.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Never return zero so a pointer always has at least one bit.
    function automatic int ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram
// Simple dual-port register array used as FIFO storage.
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write address (0..DEPTH-1)
//   wdata  - write data
//   raddr  - asynchronous read address (0..DEPTH-1)
//   rdata  - read data, combinational from raddr
// The array has no reset; contents are meaningless until written.
module fifo_ram #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param
// Parametrised single-clock FIFO with full-range fill count, programmable
// almost-full/almost-empty flags and overflow/underflow pulses.
// Ports:
//   CLOCK      - clock, rising edge
//   RESET      - synchronous active-high reset
//   CLEAR_N    - synchronous active-low flush
//   WRITE/READ - write and read requests
//   DATA_IN    - write data
//   DATA_OUT   - read data (registered)
//   F_FULL_N / F_EMPTY_N / F_AFULL_N / F_AEMPTY_N - active-low status flags
//   USE_DW     - fill count 0..DEPTH
//   OVERFLOW / UNDERFLOW - one-cycle pulses for rejected write / read
// Build option: define FIFO_FWFT_EN for first-word-fall-through output,
// where DATA_OUT presents the head entry and READ acknowledges it.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int          WIDTH     = DEF_WIDTH,
    parameter int          DEPTH     = DEF_DEPTH,
    parameter int unsigned AFULL_TH  = unsigned'(DEPTH - 2),
    parameter int unsigned AEMPTY_TH = unsigned'(DEF_AEMPTY_TH)
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    input  logic                     CLEAR_N,
    input  logic                     WRITE,
    input  logic                     READ,
    input  logic [WIDTH-1:0]         DATA_IN,
    output logic [WIDTH-1:0]         DATA_OUT,
    output logic                     F_FULL_N,
    output logic                     F_EMPTY_N,
    output logic                     F_AFULL_N,
    output logic                     F_AEMPTY_N,
    output logic [cnt_w(DEPTH)-1:0]  USE_DW,
    output logic                     OVERFLOW,
    output logic                     UNDERFLOW
);

    localparam int CNT_W = cnt_w(DEPTH);
    localparam int PTR_W = ptr_w(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             full_n_q, full_n_d;
    logic             empty_n_q, empty_n_d;
    logic             afull_n_q, afull_n_d;
    logic             aempty_n_q, aempty_n_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             rd_acc;
    logic             wr_acc;
    logic [31:0]      count_ext;
    logic             ram_we;
    logic [PTR_W-1:0] ram_raddr;
    logic [WIDTH-1:0] ram_rdata;

    // A write into a full FIFO is still accepted when a read frees a slot
    // in the same cycle. Pointers wrap by explicit compare so that
    // non-power-of-two depths never alias.
    always_comb begin
        rd_acc = READ && (count_q != '0);
        wr_acc = WRITE && ((count_q != FULL_CNT) || rd_acc);

        wr_ptr_d = wr_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end

        rd_ptr_d = rd_ptr_q;
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        count_d   = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        count_ext = 32'(count_d);

        // Flags come from the next count so they move with USE_DW.
        full_n_d    = (count_d != FULL_CNT);
        empty_n_d   = (count_d != '0);
        afull_n_d   = !(count_ext >= AFULL_TH);
        aempty_n_d  = !(count_ext <= AEMPTY_TH);
        overflow_d  = WRITE && !wr_acc;
        underflow_d = READ && !rd_acc;
    end

`ifdef FIFO_FWFT_EN
    // Look ahead at the entry that will be the head after this edge.
    assign ram_raddr = rd_ptr_d;

    // If the new head is the word being written right now it is not in the
    // array yet, so take it straight from DATA_IN. An empty FIFO holds.
    always_comb begin
        data_out_d = data_out_q;
        if (count_d != '0) begin
            if (wr_acc && (wr_ptr_q == rd_ptr_d)) begin
                data_out_d = DATA_IN;
            end else begin
                data_out_d = ram_rdata;
            end
        end
    end
`else
    assign ram_raddr = rd_ptr_q;

    // Standard mode: capture the head only when a read is accepted.
    always_comb begin
        data_out_d = data_out_q;
        if (rd_acc) begin
            data_out_d = ram_rdata;
        end
    end
`endif

    assign ram_we = wr_acc && !RESET && CLEAR_N;

    // Reset and flush share one path; requests in that cycle are ignored.
    always_ff @(posedge CLOCK) begin
        if (RESET || !CLEAR_N) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            full_n_q    <= 1'b1;
            empty_n_q   <= 1'b0;
            afull_n_q   <= 1'b1;
            aempty_n_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            full_n_q    <= full_n_d;
            empty_n_q   <= empty_n_d;
            afull_n_q   <= afull_n_d;
            aempty_n_q  <= aempty_n_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk   (CLOCK),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (DATA_IN),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign DATA_OUT   = data_out_q;
    assign F_FULL_N   = full_n_q;
    assign F_EMPTY_N  = empty_n_q;
    assign F_AFULL_N  = afull_n_q;
    assign F_AEMPTY_N = aempty_n_q;
    assign USE_DW     = count_q;
    assign OVERFLOW   = overflow_q;
    assign UNDERFLOW  = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param
// Directed bench for fifo_sync_param at DEPTH=32, WIDTH=8, AFULL_TH=30,
// AEMPTY_TH=2. A queue model predicts contents, count, flags and error
// pulses; expected read words go into a scoreboard queue that an
// independent monitor drains whenever the FIFO delivers a word.
// Works in both output modes (FIFO_FWFT_EN defined or not).
module tb_fifo_sync_param;

    localparam int WIDTH     = 8;
    localparam int DEPTH     = 32;
    localparam int AFULL_TH  = 30;
    localparam int AEMPTY_TH = 2;
    localparam int CNT_W     = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear_n;
    logic             wr;
    logic             rd;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             full_n;
    logic             empty_n;
    logic             afull_n;
    logic             aempty_n;
    logic [CNT_W-1:0] use_dw;
    logic             ovf;
    logic             unf;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] exp_q[$];
    logic             exp_ovf;
    logic             exp_unf;

    always #5 clk = ~clk;

    fifo_sync_param #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH)
    ) dut (
        .CLOCK      (clk),
        .RESET      (rst),
        .CLEAR_N    (clear_n),
        .WRITE      (wr),
        .READ       (rd),
        .DATA_IN    (din),
        .DATA_OUT   (dout),
        .F_FULL_N   (full_n),
        .F_EMPTY_N  (empty_n),
        .F_AFULL_N  (afull_n),
        .F_AEMPTY_N (aempty_n),
        .USE_DW     (use_dw),
        .OVERFLOW   (ovf),
        .UNDERFLOW  (unf)
    );

    // One counted comparison; any mismatch prints a single FAIL line.
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Status outputs against the model, sampled 1 time unit after the edge.
    task automatic checkOutput(input string tag);
        int n;
        n = model_q.size();
        check({tag, ".use_dw"},   32'(use_dw),   32'(n));
        check({tag, ".full_n"},   32'(full_n),   32'(n != DEPTH));
        check({tag, ".empty_n"},  32'(empty_n),  32'(n != 0));
        check({tag, ".afull_n"},  32'(afull_n),  32'(!(n >= AFULL_TH)));
        check({tag, ".aempty_n"}, 32'(aempty_n), 32'(!(n <= AEMPTY_TH)));
        check({tag, ".overflow"}, 32'(ovf),      32'(exp_ovf));
        check({tag, ".underflow"},32'(unf),      32'(exp_unf));
    endtask

    // Drive one cycle of requests and advance the model accordingly.
    task automatic applyStimulus(input logic w, input logic r, input logic [WIDTH-1:0] d,
                                 input string tag);
        bit rd_ok;
        bit wr_ok;
        wr  = w;
        rd  = r;
        din = d;
        rd_ok = r && (model_q.size() != 0);
        wr_ok = w && ((model_q.size() != DEPTH) || rd_ok);
        if (rd_ok) exp_q.push_back(model_q.pop_front());
        if (wr_ok) model_q.push_back(d);
        exp_ovf = w && !wr_ok;
        exp_unf = r && !rd_ok;
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
        checkOutput(tag);
    endtask

    // Reset or flush with a write pending; the write must be ignored.
    task automatic doFlush(input logic use_reset, input string tag);
        if (use_reset) rst = 1'b1;
        else clear_n = 1'b0;
        wr  = 1'b1;
        rd  = 1'b0;
        din = 8'h77;
        model_q.delete();
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        clear_n = 1'b1;
        wr      = 1'b0;
        checkOutput(tag);
        check({tag, ".data_out"}, 32'(dout), 32'h0);
    endtask

    task automatic popCompare();
        logic [WIDTH-1:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_read: got %0h expected no word", dout);
        end else begin
            e = exp_q.pop_front();
            check("read_data", 32'(dout), 32'(e));
        end
    endtask

    // Monitor: decides from the DUT handshake when a word is delivered.
`ifdef FIFO_FWFT_EN
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rd && empty_n && !rst && clear_n) popCompare();
        end
    end
`else
    logic mon_pend = 1'b0;
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (mon_pend) popCompare();
            mon_pend = rd && empty_n && !rst && clear_n;
        end
    end
`endif

    initial begin : stimulus
        rst     = 1'b0;
        clear_n = 1'b1;
        wr      = 1'b0;
        rd      = 1'b0;
        din     = '0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;

        doFlush(1'b1, "reset");

        // Fill 0x01..0x20, overflow with 0xFF, then drain in order.
        for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b1, 1'b0, 8'(i), "fill");
        applyStimulus(1'b1, 1'b0, 8'hFF, "overflow");
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 8'h00, "drain");

        // Full plus simultaneous read/write of 0xAA.
        for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b1, 1'b0, 8'(i), "fill2");
        applyStimulus(1'b1, 1'b1, 8'hAA, "full_rw");
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 8'h00, "drain2");

        // Empty plus simultaneous read/write of 0x55.
        applyStimulus(1'b1, 1'b1, 8'h55, "empty_rw");
        applyStimulus(1'b0, 1'b1, 8'h00, "read_55");
        applyStimulus(1'b0, 1'b1, 8'h00, "underflow");

        // 40 writes and 40 reads sweeping both thresholds and wrapping.
        for (int i = 0; i < 31; i++) applyStimulus(1'b1, 1'b0, 8'(8'h40 + i), "wrap_up");
        for (int i = 31; i < 40; i++) applyStimulus(1'b1, 1'b1, 8'(8'h40 + i), "wrap_rw");
        for (int i = 0; i < 31; i++) applyStimulus(1'b0, 1'b1, 8'h00, "wrap_down");

        // Flush with 10 words stored and a write in the same cycle.
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 8'(8'h90 + i), "pre_clear");
        doFlush(1'b0, "clear");
        applyStimulus(1'b1, 1'b0, 8'h5A, "post_clear_wr");
        applyStimulus(1'b0, 1'b1, 8'h00, "post_clear_rd");

        // Reset in the middle of activity.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'(8'hC0 + i), "pre_reset");
        doFlush(1'b1, "mid_reset");
        applyStimulus(1'b1, 1'b0, 8'h3C, "post_reset_wr");
        applyStimulus(1'b0, 1'b1, 8'h00, "post_reset_rd");

        applyStimulus(1'b0, 1'b0, 8'h00, "idle");
        applyStimulus(1'b0, 1'b0, 8'h00, "idle");
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
